// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined MIPS instruction-decode stage.
// It decodes the incoming instruction and reads two GPRs from an NREG x XLEN
// register file that has one writeback port. The results are registered into
// an ID/EX register, with valid/ready handshakes on both sides. A load-use
// hazard against the instruction held in ID/EX inserts a one-cycle bubble.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a register read
// that hits the same-cycle writeback returns wb_data instead of the stored value.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Ins,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      Rs,
  output logic [4:0]      Rt,
  output logic [4:0]      Rd,
  output logic [XLEN-1:0] Rdata1,
  output logic [XLEN-1:0] Rdata2,
  output logic [XLEN-1:0] ImmExt,
  output logic [25:0]     JAddr,
  output logic [1:0]      ALUOp,
  output logic            RegDst,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            Jump,
  output logic            illegal
);

  localparam int         AW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG_W = 6'(NREG);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef struct packed {
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [25:0]     jaddr;
    logic [1:0]      alu_op;
    logic            reg_dst;
    logic            alu_src;
    logic            mem_to_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } idex_t;

  idex_t           idex_q, idex_d, dec_s;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] gpr_q [NREG];
  logic [XLEN-1:0] gpr_d [NREG];
  logic [5:0]      op_s;
  logic            stall_s, adv_s, wb_hit_s;

  // Read one port. Index 0 and indices outside the file return 0.
  // With the bypass enabled, a read that matches the live write returns wb_data.
  function automatic logic [XLEN-1:0] rd_sel(input logic [4:0] idx,
                                             input logic [XLEN-1:0] stored,
                                             input logic wbe,
                                             input logic [4:0] wba,
                                             input logic [XLEN-1:0] wbd);
    logic [XLEN-1:0] val;
    if ((idx == 5'd0) || ({1'b0, idx} >= NREG_W)) begin
      val = '0;
    end else begin
`ifdef WB_BYPASS_EN
      if (wbe && (wba == idx)) begin
        val = wbd;
      end else begin
        val = stored;
      end
`else
      val = stored;
      if (wbe && (wba == idx)) begin
        val = stored;
      end else begin
        val = stored;
      end
`endif
    end
    return val;
  endfunction

  assign op_s = Ins[31:26];

  // Decode the incoming instruction into the fields and control bits of ID/EX.
  always_comb begin
    dec_s        = '0;
    dec_s.rs     = Ins[25:21];
    dec_s.rt     = Ins[20:16];
    dec_s.rd     = Ins[15:11];
    dec_s.imm    = {{(XLEN-16){Ins[15]}}, Ins[15:0]};
    dec_s.jaddr  = Ins[25:0];
    dec_s.rdata1 = rd_sel(Ins[25:21], gpr_q[Ins[21+AW-1:21]], wb_en, wb_addr, wb_data);
    dec_s.rdata2 = rd_sel(Ins[20:16], gpr_q[Ins[16+AW-1:16]], wb_en, wb_addr, wb_data);
    case (op_s)
      OP_R: begin
        dec_s.reg_dst   = 1'b1;
        dec_s.reg_write = 1'b1;
        dec_s.alu_op    = 2'b10;
      end
      OP_ADDI: begin
        dec_s.alu_src   = 1'b1;
        dec_s.reg_write = 1'b1;
      end
      OP_LW: begin
        dec_s.alu_src    = 1'b1;
        dec_s.mem_to_reg = 1'b1;
        dec_s.reg_write  = 1'b1;
        dec_s.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec_s.alu_src   = 1'b1;
        dec_s.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_s.branch = 1'b1;
        dec_s.alu_op = 2'b01;
      end
      OP_J: begin
        dec_s.jump = 1'b1;
      end
      default: begin
        dec_s.illegal = 1'b1;
      end
    endcase
  end

  // Detect a load-use hazard and decide whether ID/EX can advance.
  always_comb begin
    stall_s = out_valid_q && idex_q.mem_read && (idex_q.rt != 5'd0) &&
              (((idex_q.rt == Ins[25:21]) && (op_s != OP_J)) ||
               ((idex_q.rt == Ins[20:16]) &&
                ((op_s == OP_R) || (op_s == OP_SW) || (op_s == OP_BEQ))));
    adv_s    = !out_valid_q || out_ready;
    in_ready = adv_s && !stall_s && !flush;
  end

  // Compute the next ID/EX contents: flush first, then the stall/bubble, then the handshake.
  always_comb begin
    idex_d      = idex_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (adv_s) begin
      if (in_valid && !stall_s) begin
        idex_d      = dec_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Compute the next register-file contents. Writes to index 0 or beyond NREG are dropped.
  always_comb begin
    gpr_d    = gpr_q;
    wb_hit_s = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREG_W);
    if (wb_hit_s) begin
      gpr_d[wb_addr[AW-1:0]] = wb_data;
    end else begin
      gpr_d[0] = gpr_q[0];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idex_q      <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
    end else begin
      idex_q      <= idex_d;
      out_valid_q <= out_valid_d;
      gpr_q       <= gpr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Rs        = idex_q.rs;
  assign Rt        = idex_q.rt;
  assign Rd        = idex_q.rd;
  assign Rdata1    = idex_q.rdata1;
  assign Rdata2    = idex_q.rdata2;
  assign ImmExt    = idex_q.imm;
  assign JAddr     = idex_q.jaddr;
  assign ALUOp     = idex_q.alu_op;
  assign RegDst    = idex_q.reg_dst;
  assign ALUSrc    = idex_q.alu_src;
  assign MemtoReg  = idex_q.mem_to_reg;
  assign RegWrite  = idex_q.reg_write;
  assign MemRead   = idex_q.mem_read;
  assign MemWrite  = idex_q.mem_write;
  assign Branch    = idex_q.branch;
  assign Jump      = idex_q.jump;
  assign illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed testbench for id_stage_pipe. It has two instances: the default
// XLEN=32/NREG=32 build, and an XLEN=64/NREG=16 build that checks wide sign
// extension and reads of an index outside the register file.
module tb_id_stage_pipe;

  logic        CLK = 1'b0;
  logic        RST, in_valid, flush, wb_en, out_ready;
  logic [31:0] Ins;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [63:0] wb_data64;

  logic        in_ready, out_valid;
  logic [4:0]  Rs, Rt, Rd;
  logic [31:0] Rdata1, Rdata2, ImmExt;
  logic [25:0] JAddr;
  logic [1:0]  ALUOp;
  logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, illegal;

  logic        w_in_ready, w_out_valid;
  logic [4:0]  w_Rs, w_Rt, w_Rd;
  logic [63:0] w_Rdata1, w_Rdata2, w_ImmExt;
  logic [25:0] w_JAddr;
  logic [1:0]  w_ALUOp;
  logic        w_RegDst, w_ALUSrc, w_MemtoReg, w_RegWrite, w_MemRead, w_MemWrite;
  logic        w_Branch, w_Jump, w_illegal;

  int checks = 0;
  int errors = 0;

  assign wb_data64 = {32'h0000_0000, wb_data};

  always #5 CLK = ~CLK;

  id_stage_pipe #(.XLEN(32), .NREG(32)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .Ins(Ins),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .ImmExt(ImmExt), .JAddr(JAddr), .ALUOp(ALUOp),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .illegal(illegal)
  );

  id_stage_pipe #(.XLEN(64), .NREG(16)) dut64 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(w_in_ready), .Ins(Ins),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data64),
    .out_valid(w_out_valid), .out_ready(out_ready), .Rs(w_Rs), .Rt(w_Rt), .Rd(w_Rd),
    .Rdata1(w_Rdata1), .Rdata2(w_Rdata2), .ImmExt(w_ImmExt), .JAddr(w_JAddr), .ALUOp(w_ALUOp),
    .RegDst(w_RegDst), .ALUSrc(w_ALUSrc), .MemtoReg(w_MemtoReg), .RegWrite(w_RegWrite),
    .MemRead(w_MemRead), .MemWrite(w_MemWrite), .Branch(w_Branch), .Jump(w_Jump),
    .illegal(w_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Let the inputs settle, then check the combinational in_ready.
  task automatic settle;
    #1;
  endtask

  // Advance one clock edge and sample 1 time unit after it.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    Ins = 32'h0000_0000; wb_addr = 5'd0; wb_data = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_rdata1", {32'd0, Rdata1}, 64'd0);
    RST = 1'b0;
    settle();
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Test 1: add $3,$1,$2 on a freshly reset register file.
    Ins = 32'h0022_1820; in_valid = 1'b1;
    tick();
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_rdata1", {32'd0, Rdata1}, 64'd0);
    chk("t1_rdata2", {32'd0, Rdata2}, 64'd0);

    // Test 2: write r1 and r2, then decode the add.
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h11;
    tick();
    chk("t2_idle_out_valid", {63'd0, out_valid}, 64'd0);
    wb_addr = 5'd2; wb_data = 32'h22;
    tick();
    wb_en = 1'b0;
    Ins = 32'h0022_1820; in_valid = 1'b1;
    tick();
    chk("t2_rs", {59'd0, Rs}, 64'd1);
    chk("t2_rt", {59'd0, Rt}, 64'd2);
    chk("t2_rd", {59'd0, Rd}, 64'd3);
    chk("t2_rdata1", {32'd0, Rdata1}, 64'h11);
    chk("t2_rdata2", {32'd0, Rdata2}, 64'h22);
    chk("t2_regdst", {63'd0, RegDst}, 64'd1);
    chk("t2_regwrite", {63'd0, RegWrite}, 64'd1);
    chk("t2_aluop", {62'd0, ALUOp}, 64'd2);
    chk("t2_alusrc", {63'd0, ALUSrc}, 64'd0);

    // Test 3: addi $2,$1,-4 sign-extends the immediate at both widths.
    Ins = 32'h2022_FFFC;
    tick();
    chk("t3_immext", {32'd0, ImmExt}, 64'hFFFF_FFFC);
    chk("t3_immext64", w_ImmExt, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t3_alusrc", {63'd0, ALUSrc}, 64'd1);
    chk("t3_regwrite", {63'd0, RegWrite}, 64'd1);
    chk("t3_regdst", {63'd0, RegDst}, 64'd0);

    // Test 4a: lw $2 followed by add $3,$2,$2 stalls for one bubble.
    Ins = 32'h8C22_0004;
    tick();
    chk("t4_lw_memread", {63'd0, MemRead}, 64'd1);
    chk("t4_lw_memtoreg", {63'd0, MemtoReg}, 64'd1);
    Ins = 32'h0042_1820;
    settle();
    chk("t4_stall_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("t4_bubble_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_after_bubble_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("t4_add_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_add_rs", {59'd0, Rs}, 64'd2);
    chk("t4_add_memread", {63'd0, MemRead}, 64'd0);

    // Test 4b: sw $2,0($5) after lw $2 stalls on its rt field.
    Ins = 32'h8C22_0004;
    tick();
    Ins = 32'hACA2_0000;
    settle();
    chk("t4_sw_stall_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("t4_sw_bubble", {63'd0, out_valid}, 64'd0);
    tick();
    chk("t4_sw_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_sw_memwrite", {63'd0, MemWrite}, 64'd1);

    // Test 4c: addi $2,$5,1 after lw $2 only writes r2, so it does not stall.
    Ins = 32'h8C22_0004;
    tick();
    Ins = 32'h20A2_0001;
    settle();
    chk("t4_addi_no_stall", {63'd0, in_ready}, 64'd1);
    tick();
    chk("t4_addi_out_valid", {63'd0, out_valid}, 64'd1);

    // Test 5: backpressure holds everything for three cycles, then a flush.
    Ins = 32'h0022_1820;
    tick();
    out_ready = 1'b0; Ins = 32'h2022_FFFC;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t5_bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      chk("t5_bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("t5_bp_rd", {59'd0, Rd}, 64'd3);
      chk("t5_bp_immext", {32'd0, ImmExt}, 64'h0000_1820);
      chk("t5_bp_regdst", {63'd0, RegDst}, 64'd1);
    end
    flush = 1'b1;
    settle();
    chk("t5_flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("t5_flush_out_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; out_ready = 1'b1;

    // Test 6: write r5 in the same cycle that add $0,$5,$0 reads it.
    Ins = 32'h00A0_0020; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAB;
    tick();
`ifdef WB_BYPASS_EN
    chk("t6_same_cycle_rdata1", {32'd0, Rdata1}, 64'hAB);
`else
    chk("t6_same_cycle_rdata1", {32'd0, Rdata1}, 64'h0);
`endif
    wb_en = 1'b0;
    tick();
    chk("t6_next_rdata1", {32'd0, Rdata1}, 64'hAB);

    // Test 7: a write to r0 is ignored, even in the same cycle as the read.
    Ins = 32'h0000_0020; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
    tick();
    chk("t7_r0_same_cycle", {32'd0, Rdata1}, 64'd0);
    wb_en = 1'b0;
    tick();
    chk("t7_r0_after", {32'd0, Rdata1}, 64'd0);
    Ins = 32'hFC00_0000;
    tick();
    chk("t7_illegal", {63'd0, illegal}, 64'd1);
    chk("t7_illegal_valid", {63'd0, out_valid}, 64'd1);
    chk("t7_illegal_ctrl",
        {54'd0, ALUOp, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump},
        64'd0);

    // Jump and beq decode.
    Ins = 32'h0800_0123;
    tick();
    chk("j_jump", {63'd0, Jump}, 64'd1);
    chk("j_jaddr", {38'd0, JAddr}, 64'h123);
    Ins = 32'h1022_0005;
    tick();
    chk("beq_branch", {63'd0, Branch}, 64'd1);
    chk("beq_aluop", {62'd0, ALUOp}, 64'd1);
    chk("beq_illegal", {63'd0, illegal}, 64'd0);

    // Index 20 exists with NREG=32 but is out of range with NREG=16.
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h55;
    tick();
    wb_en = 1'b0; in_valid = 1'b1; Ins = 32'h0280_0020;
    tick();
    chk("nreg32_r20", {32'd0, Rdata1}, 64'h55);
    chk("nreg16_r20", w_Rdata1, 64'd0);

    // A reset mid-operation discards the held instruction and clears the GPRs.
    RST = 1'b1;
    tick();
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_rs", {59'd0, Rs}, 64'd0);
    RST = 1'b0; Ins = 32'h0022_1820;
    tick();
    chk("midrst_gpr_rdata1", {32'd0, Rdata1}, 64'd0);
    chk("midrst_out_valid2", {63'd0, out_valid}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
